// File: rtl/cvp14_pkg.sv
// cvp14_pkg: constants shared by the CVP14 vector datapath blocks.
// Holds opcode values, default vector geometry, memory-op encoding and the
// state enumeration of vec_mem_unit.
package cvp14_pkg;

    // Control-FSM opcodes handled by vec_mem_unit
    localparam logic [3:0] VLD = 4'b0100;
    localparam logic [3:0] VST = 4'b0101;

    // Default vector geometry
    localparam int ELEM_W_DEF   = 16;
    localparam int NUM_ELEM_DEF = 16;

    // Memory operation encoding on the op input
    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    // vec_mem_unit sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_STORE = 3'd3,
        ST_FIN   = 3'd4
    } vmuState_t;

    // 16-bit address step; the carry out is dropped so addresses wrap
    function automatic logic [15:0] addrStep(input logic [15:0] addr, input logic [15:0] step);
        return addr + step;
    endfunction

endpackage

// File: rtl/vmu_addr_gen.sv
// vmu_addr_gen: element address and element counter for vec_mem_unit.
// Element 0 is issued by the parent straight from base_addr; this block
// keeps the address of the next element (base + k*stride, built by
// accumulation) and flags when all NUM_ELEM elements have been issued.
module vmu_addr_gen
    import cvp14_pkg::*;
#(
    parameter int NUM_ELEM = NUM_ELEM_DEF
) (
    input  logic        Clk1,
    input  logic        Reset,
    input  logic        load,
    input  logic        advance,
    input  logic [15:0] baseAddr,
    input  logic [15:0] stride,
    output logic [15:0] nextAddr,
    output logic        allIssued
);

    localparam int CNT_W = $clog2(NUM_ELEM) + 1;

    logic [15:0]      nextAddr_r;
    logic [15:0]      stride_r;
    logic [CNT_W-1:0] elemCnt_r;

    // Accumulate the address and count issued elements; load primes element 1.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            nextAddr_r <= 16'h0000;
            stride_r   <= 16'h0000;
            elemCnt_r  <= {CNT_W{1'b0}};
        end else if (load) begin
            nextAddr_r <= addrStep(baseAddr, stride);
            stride_r   <= stride;
            elemCnt_r  <= CNT_W'(1);
        end else if (advance) begin
            nextAddr_r <= addrStep(nextAddr_r, stride_r);
            stride_r   <= stride_r;
            elemCnt_r  <= elemCnt_r + CNT_W'(1);
        end else begin
            nextAddr_r <= nextAddr_r;
            stride_r   <= stride_r;
            elemCnt_r  <= elemCnt_r;
        end
    end

    assign nextAddr  = nextAddr_r;
    assign allIssued = (elemCnt_r == CNT_W'(NUM_ELEM));

endmodule

// File: rtl/vec_mem_unit.sv
// vec_mem_unit: VLD/VST sequencer between the vector register file and the
// 16-bit memory bus. A load issues NUM_ELEM reads, collects the words in a
// shadow buffer and writes the whole vector to vec_out with a one-cycle
// vec_wr strobe; a store latches a vector and streams it out as NUM_ELEM
// writes. Optional macro VMU_STRIDE_EN adds a stride input (default step 1).
module vec_mem_unit
    import cvp14_pkg::*;
#(
    parameter int NUM_ELEM = NUM_ELEM_DEF,
    parameter int ELEM_W   = ELEM_W_DEF
) (
    input  logic                       Clk1,
    input  logic                       Reset,
    input  logic                       start,
    input  logic                       op,
    input  logic [15:0]                base_addr,
`ifdef VMU_STRIDE_EN
    input  logic [15:0]                stride,
`endif
    input  logic [NUM_ELEM*ELEM_W-1:0] vec_in,
    input  logic [ELEM_W-1:0]          mem_din,
    output logic [15:0]                mem_addr,
    output logic                       mem_rd,
    output logic                       mem_wr,
    output logic [ELEM_W-1:0]          mem_dout,
    output logic [NUM_ELEM*ELEM_W-1:0] vec_out,
    output logic                       vec_wr,
    output logic                       busy,
    output logic                       done
);

    localparam int VEC_W = NUM_ELEM * ELEM_W;

    vmuState_t        state_r;
    vmuState_t        stateNext_s;
    logic             accept_s;
    logic             issue_s;
    logic             memRdNext_s;
    logic             memWrNext_s;
    logic             doneNext_s;
    logic             vecWrNext_s;
    logic             allIssued_s;
    logic [15:0]      nextAddr_s;
    logic [15:0]      stride_s;
    logic [VEC_W-1:0] loadVec_s;

    logic [15:0]       memAddr_r;
    logic              memRd_r;
    logic              memWr_r;
    logic [ELEM_W-1:0] memDout_r;
    logic [VEC_W-1:0]  vecOut_r;
    logic              vecWr_r;
    logic              busy_r;
    logic              done_r;
    logic              rdDataValid_r;
    logic [VEC_W-1:0]  dataBuf_r;

`ifdef VMU_STRIDE_EN
    assign stride_s = stride;
`else
    assign stride_s = 16'd1;
`endif

    // Read data arrives in element order, so shifting in at the top leaves
    // element 0 at the bottom once all NUM_ELEM words have been taken.
    assign loadVec_s = {mem_din, dataBuf_r[VEC_W-1:ELEM_W]};

    vmu_addr_gen #(
        .NUM_ELEM (NUM_ELEM)
    ) uAddrGen (
        .Clk1      (Clk1),
        .Reset     (Reset),
        .load      (accept_s),
        .advance   (issue_s),
        .baseAddr  (base_addr),
        .stride    (stride_s),
        .nextAddr  (nextAddr_s),
        .allIssued (allIssued_s)
    );

    // State register.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Next state and next values of the registered strobes.
    // FIN is the store done cycle; it takes a new start like IDLE so a
    // request can be accepted on the edge that ends the done pulse.
    always_comb begin
        stateNext_s = state_r;
        accept_s    = 1'b0;
        issue_s     = 1'b0;
        memRdNext_s = 1'b0;
        memWrNext_s = 1'b0;
        doneNext_s  = 1'b0;
        vecWrNext_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_FIN: begin
                if (start) begin
                    accept_s = 1'b1;
                    if (op == OP_STORE) begin
                        stateNext_s = ST_STORE;
                        memWrNext_s = 1'b1;
                    end else begin
                        stateNext_s = ST_LOAD;
                        memRdNext_s = 1'b1;
                    end
                end else begin
                    stateNext_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!allIssued_s) begin
                    memRdNext_s = 1'b1;
                    issue_s     = 1'b1;
                end else begin
                    stateNext_s = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                stateNext_s = ST_IDLE;
                vecWrNext_s = 1'b1;
                doneNext_s  = 1'b1;
            end
            ST_STORE: begin
                if (!allIssued_s) begin
                    memWrNext_s = 1'b1;
                    issue_s     = 1'b1;
                end else begin
                    stateNext_s = ST_FIN;
                    doneNext_s  = 1'b1;
                end
            end
            default: begin
                stateNext_s = ST_IDLE;
            end
        endcase
    end

    // Registered bus strobes, address, write data and status outputs.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            memAddr_r     <= 16'h0000;
            memRd_r       <= 1'b0;
            memWr_r       <= 1'b0;
            memDout_r     <= {ELEM_W{1'b0}};
            vecWr_r       <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            rdDataValid_r <= 1'b0;
        end else begin
            memRd_r       <= memRdNext_s;
            memWr_r       <= memWrNext_s;
            vecWr_r       <= vecWrNext_s;
            done_r        <= doneNext_s;
            busy_r        <= (stateNext_s != ST_IDLE);
            rdDataValid_r <= memRd_r;
            if (accept_s) begin
                memAddr_r <= base_addr;
            end else if (issue_s) begin
                memAddr_r <= nextAddr_s;
            end else begin
                memAddr_r <= memAddr_r;
            end
            if (accept_s && memWrNext_s) begin
                memDout_r <= vec_in[ELEM_W-1:0];
            end else if (issue_s && memWrNext_s) begin
                memDout_r <= dataBuf_r[ELEM_W-1:0];
            end else begin
                memDout_r <= memDout_r;
            end
        end
    end

    // Shared shadow buffer: store source shifted out, or load data shifted in.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            dataBuf_r <= {VEC_W{1'b0}};
        end else if (accept_s && memWrNext_s) begin
            dataBuf_r <= {{ELEM_W{1'b0}}, vec_in[VEC_W-1:ELEM_W]};
        end else if (issue_s && memWrNext_s) begin
            dataBuf_r <= {{ELEM_W{1'b0}}, dataBuf_r[VEC_W-1:ELEM_W]};
        end else if (rdDataValid_r) begin
            dataBuf_r <= loadVec_s;
        end else begin
            dataBuf_r <= dataBuf_r;
        end
    end

    // vec_out changes only when a complete load vector is written out.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            vecOut_r <= {VEC_W{1'b0}};
        end else if (vecWrNext_s) begin
            vecOut_r <= loadVec_s;
        end else begin
            vecOut_r <= vecOut_r;
        end
    end

    assign mem_addr = memAddr_r;
    assign mem_rd   = memRd_r;
    assign mem_wr   = memWr_r;
    assign mem_dout = memDout_r;
    assign vec_out  = vecOut_r;
    assign vec_wr   = vecWr_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule
